// File: rtl/data_mem_bank_arbiter.sv
// Word-interleaved round-robin arbiter between OBI requesters and scratchpad banks.
// Grants one requester per bank per cycle and routes each bank's one-cycle response back to its owner.
module data_mem_bank_arbiter #(
  parameter int NUM_MASTERS        = 4,
  parameter int DATA_MEM_NUM_BANKS = 4,
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 32
) (
  input  logic                                                clk_i,
  input  logic                                                rst_ni,
  input  logic [NUM_MASTERS-1:0]                              mst_req_i,
  output logic [NUM_MASTERS-1:0]                              mst_gnt_o,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]              mst_addr_i,
  input  logic [NUM_MASTERS-1:0]                              mst_we_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]            mst_be_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]              mst_wdata_i,
  output logic [NUM_MASTERS-1:0]                              mst_rvalid_o,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]              mst_rdata_o,
  output logic [DATA_MEM_NUM_BANKS-1:0]                       bank_req_o,
  input  logic [DATA_MEM_NUM_BANKS-1:0]                       bank_gnt_i,
  output logic [DATA_MEM_NUM_BANKS-1:0][ADDR_WIDTH-1:0]       bank_addr_o,
  output logic [DATA_MEM_NUM_BANKS-1:0]                       bank_we_o,
  output logic [DATA_MEM_NUM_BANKS-1:0][DATA_WIDTH/8-1:0]     bank_be_o,
  output logic [DATA_MEM_NUM_BANKS-1:0][DATA_WIDTH-1:0]       bank_wdata_o,
  input  logic [DATA_MEM_NUM_BANKS-1:0]                       bank_rvalid_i,
  input  logic [DATA_MEM_NUM_BANKS-1:0][DATA_WIDTH-1:0]       bank_rdata_i
);
  // OBI handshake: a transfer happens on a bank in any cycle where bank_req_o & bank_gnt_i;
  // the requester's gnt mirrors that, and its rvalid arrives exactly one cycle later.
  localparam int MW = $clog2(NUM_MASTERS);
  localparam int BW = $clog2(DATA_MEM_NUM_BANKS);

  logic [NUM_MASTERS-1:0][BW-1:0]        tgt;
  logic [DATA_MEM_NUM_BANKS-1:0][MW-1:0] rr_ptr;
  logic [DATA_MEM_NUM_BANKS-1:0][MW-1:0] win;
  logic [DATA_MEM_NUM_BANKS-1:0][MW-1:0] own_id;
  logic [DATA_MEM_NUM_BANKS-1:0]         found;
  logic [DATA_MEM_NUM_BANKS-1:0]         own_vld;
  logic [DATA_MEM_NUM_BANKS-1:0]         hs;

  always_comb begin : decode
    for (int m = 0; m < NUM_MASTERS; m++) begin
      tgt[m] = mst_addr_i[m][2 +: BW];
    end
  end

  always_comb begin : arbitrate
    int                     idx;
    logic [NUM_MASTERS-1:0] hit;
    idx          = 0;
    hit          = '0;
    found        = '0;
    win          = '0;
    bank_req_o   = '0;
    bank_addr_o  = '0;
    bank_we_o    = '0;
    bank_be_o    = '0;
    bank_wdata_o = '0;
    for (int b = 0; b < DATA_MEM_NUM_BANKS; b++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        hit[m] = mst_req_i[m] && (tgt[m] == BW'(b));
      end
      // Search upward from the round-robin pointer, wrapping at NUM_MASTERS.
      for (int k = 0; k < NUM_MASTERS; k++) begin
        idx = int'(rr_ptr[b]) + k;
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
        if (!found[b] && hit[idx]) begin
          found[b] = 1'b1;
          win[b]   = MW'(idx);
        end
      end
      bank_req_o[b] = found[b];
      if (found[b]) begin
        bank_we_o[b]    = mst_we_i[win[b]];
        bank_be_o[b]    = mst_be_i[win[b]];
        bank_wdata_o[b] = mst_wdata_i[win[b]];
        bank_addr_o[b]  = {{BW{1'b0}}, mst_addr_i[win[b]][ADDR_WIDTH-1:2+BW],
                           mst_addr_i[win[b]][1:0]};
      end
    end
    hs = found & bank_gnt_i;
  end

  always_comb begin : route
    mst_gnt_o    = '0;
    mst_rvalid_o = '0;
    mst_rdata_o  = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      mst_gnt_o[m] = hs[tgt[m]] && (win[tgt[m]] == MW'(m));
    end
    // A requester owns at most one bank per cycle, so at most one term matches.
    for (int b = 0; b < DATA_MEM_NUM_BANKS; b++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (bank_rvalid_i[b] && own_vld[b] && (own_id[b] == MW'(m))) begin
          mst_rvalid_o[m] = 1'b1;
          mst_rdata_o[m]  = bank_rdata_i[b];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr  <= '0;
      own_vld <= '0;
      own_id  <= '0;
    end else begin
      for (int b = 0; b < DATA_MEM_NUM_BANKS; b++) begin
        own_vld[b] <= hs[b];
        if (hs[b]) begin
          own_id[b] <= win[b];
          rr_ptr[b] <= (win[b] == MW'(NUM_MASTERS - 1)) ? '0 : win[b] + MW'(1);
        end
      end
    end
  end

endmodule
